// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: instruction-memory request/ack, decode valid/ready, and
// the execute-side controls (halt, redirect) that steer the fetch sequencer.
interface fetch_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              halt_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_ack_i;
    logic [DATA_W-1:0] imem_rdata_i;
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic [ADDR_W-1:0] inst_pc4_o;
    logic              inst_ready_i;
    logic              busy_o;
    logic [1:0]        fetch_state;

    modport master (
        input  halt_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i, inst_ready_i,
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_pc4_o,
               busy_o, fetch_state
    );

    modport slave (
        output halt_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i, inst_ready_i,
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_pc4_o,
               busy_o, fetch_state
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, fetches from instruction memory and hands
// instructions to decode, honouring branch redirects even mid-fetch.
module fetch_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                PC_STEP  = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    fetch_ctrl_if.master bus
);
    // Handshakes: a memory transfer completes on a rising edge where
    // imem_req_o=1 and imem_ack_i=1; a decode transfer completes on an edge
    // where inst_valid_o=1 and inst_ready_i=1. Neither side withdraws early.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pend_pc;
    logic              kill;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            pend_pc <= RESET_PC;
            kill    <= 1'b0;
            inst    <= '0;
            inst_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.redirect_i) pc <= bus.redirect_pc_i;
                    if (!bus.halt_i) state <= REQ;
                end
                REQ: begin
                    if (bus.imem_ack_i) begin
                        // A redirect in the ack cycle supersedes any parked target.
                        if (bus.redirect_i) begin
                            pc   <= bus.redirect_pc_i;
                            kill <= 1'b0;
                        end else if (kill) begin
                            pc   <= pend_pc;
                            kill <= 1'b0;
                        end else begin
                            inst    <= bus.imem_rdata_i;
                            inst_pc <= pc;
                            pc      <= pc + STEP;
                            state   <= OUT;
                        end
                    end else if (bus.redirect_i) begin
                        // Address must stay stable, so park the target until the ack.
                        pend_pc <= bus.redirect_pc_i;
                        kill    <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.redirect_i) begin
                        pc    <= bus.redirect_pc_i;
                        state <= bus.halt_i ? IDLE : REQ;
                    end else if (bus.inst_ready_i) begin
                        state <= bus.halt_i ? IDLE : REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_req_o   = (state == REQ);
    assign bus.imem_addr_o  = pc;
    assign bus.inst_valid_o = (state == OUT);
    assign bus.inst_o       = inst;
    assign bus.inst_pc_o    = inst_pc;
    assign bus.inst_pc4_o   = inst_pc + STEP;
    assign bus.busy_o       = (state != IDLE);
    assign bus.fetch_state  = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one task per scenario, inline comparisons
// against hand-computed addresses, instruction words and handshake levels.
module tb_fetch_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    fetch_ctrl #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'h0000), .PC_STEP(4)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] word(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.halt_i        = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.imem_ack_i    = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.inst_ready_i  = 1'b1;
    endtask

    // Leaves the DUT in IDLE just after reset release; next edge enters REQ.
    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %0h want 0", bus.imem_req_o); end
        checks++; if (bus.imem_addr_o !== 16'h0000) begin errors++; $display("FAIL rst_addr got %0h want 0", bus.imem_addr_o); end
        checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", bus.inst_valid_o); end
        checks++; if (bus.inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst got %0h want 0", bus.inst_o); end
        checks++; if (bus.inst_pc_o !== 16'h0) begin errors++; $display("FAIL rst_inst_pc got %0h want 0", bus.inst_pc_o); end
        checks++; if (bus.inst_pc4_o !== 16'h0004) begin errors++; $display("FAIL rst_pc4 got %0h want 4", bus.inst_pc4_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h want 0", bus.busy_o); end
        apply_reset();
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_release_req got %0h want 0", bus.imem_req_o); end
        cycle();
        checks++; if (bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL rst_first_req got %0h want 1", bus.imem_req_o); end
    endtask

    task automatic test_sequential();
        logic [15:0] a;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            a = 16'(4 * k);
            cycle();
            checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== a) begin
                errors++; $display("FAIL seq_req%0d got req=%0h addr=%0h want req=1 addr=%0h", k, bus.imem_req_o, bus.imem_addr_o, a); end
            checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL seq_valid_low%0d got %0h want 0", k, bus.inst_valid_o); end
            bus.imem_ack_i = 1'b1; bus.imem_rdata_i = word(a);
            cycle();
            bus.imem_ack_i = 1'b0;
            checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== a || bus.inst_o !== word(a)) begin
                errors++; $display("FAIL seq_out%0d got v=%0h pc=%0h inst=%0h want v=1 pc=%0h inst=%0h", k, bus.inst_valid_o, bus.inst_pc_o, bus.inst_o, a, word(a)); end
            checks++; if (bus.inst_pc4_o !== a + 16'd4 || bus.imem_req_o !== 1'b0) begin
                errors++; $display("FAIL seq_pc4%0d got pc4=%0h req=%0h want pc4=%0h req=0", k, bus.inst_pc4_o, bus.imem_req_o, a + 16'd4); end
        end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        cycle();
        cycle();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 16'h0040;
        cycle();
        bus.redirect_i = 1'b0;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 16'h0000) begin
            errors++; $display("FAIL rdw_hold got req=%0h addr=%0h want req=1 addr=0", bus.imem_req_o, bus.imem_addr_o); end
        cycle();
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = word(16'h0000);
        cycle();
        bus.imem_ack_i = 1'b0;
        checks++; if (bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 16'h0040) begin
            errors++; $display("FAIL rdw_new got v=%0h req=%0h addr=%0h want v=0 req=1 addr=40", bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o); end
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = word(16'h0040);
        cycle();
        bus.imem_ack_i = 1'b0;
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 16'h0040 || bus.inst_o !== word(16'h0040)) begin
            errors++; $display("FAIL rdw_deliver got v=%0h pc=%0h inst=%0h want v=1 pc=40 inst=%0h", bus.inst_valid_o, bus.inst_pc_o, bus.inst_o, word(16'h0040)); end
    endtask

    task automatic test_latest_redirect();
        apply_reset();
        cycle();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 16'h0080;
        cycle();
        bus.redirect_pc_i = 16'h0090;
        cycle();
        bus.redirect_i = 1'b0;
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = word(16'h0000);
        cycle();
        bus.imem_ack_i = 1'b0;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 16'h0090 || bus.inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL latest got req=%0h addr=%0h v=%0h want req=1 addr=90 v=0", bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o); end
    endtask

    task automatic test_redirect_ack();
        apply_reset();
        cycle();
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = word(16'h0000);
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 16'h0100;
        cycle();
        bus.imem_ack_i = 1'b0; bus.redirect_i = 1'b0;
        checks++; if (bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 16'h0100) begin
            errors++; $display("FAIL rda_new got v=%0h req=%0h addr=%0h want v=0 req=1 addr=100", bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o); end
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = word(16'h0100);
        cycle();
        bus.imem_ack_i = 1'b0;
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 16'h0100) begin
            errors++; $display("FAIL rda_deliver got v=%0h pc=%0h want v=1 pc=100", bus.inst_valid_o, bus.inst_pc_o); end
    endtask

    task automatic test_stall();
        apply_reset();
        bus.inst_ready_i = 1'b0;
        cycle();
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = word(16'h0000);
        cycle();
        bus.imem_ack_i = 1'b0; bus.imem_rdata_i = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== word(16'h0000) || bus.inst_pc_o !== 16'h0000 || bus.imem_req_o !== 1'b0) begin
                errors++; $display("FAIL stall%0d got v=%0h inst=%0h pc=%0h req=%0h want v=1 inst=%0h pc=0 req=0", k, bus.inst_valid_o, bus.inst_o, bus.inst_pc_o, bus.imem_req_o, word(16'h0000)); end
            cycle();
        end
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 16'h0020;
        cycle();
        bus.redirect_i = 1'b0; bus.inst_ready_i = 1'b1;
        checks++; if (bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 16'h0020) begin
            errors++; $display("FAIL stall_redirect got v=%0h req=%0h addr=%0h want v=0 req=1 addr=20", bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_wrap();
        apply_reset();
        cycle();
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = word(16'h0000);
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 16'hFFFC;
        cycle();
        bus.redirect_i = 1'b0; bus.imem_rdata_i = word(16'hFFFC);
        cycle();
        bus.imem_ack_i = 1'b0;
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 16'hFFFC || bus.inst_pc4_o !== 16'h0000) begin
            errors++; $display("FAIL wrap_pc4 got v=%0h pc=%0h pc4=%0h want v=1 pc=fffc pc4=0", bus.inst_valid_o, bus.inst_pc_o, bus.inst_pc4_o); end
        cycle();
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 16'h0000) begin
            errors++; $display("FAIL wrap_addr got req=%0h addr=%0h want req=1 addr=0", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_halt();
        apply_reset();
        cycle();
        bus.halt_i = 1'b1;
        cycle();
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 16'h0000) begin
            errors++; $display("FAIL halt_req_held got req=%0h addr=%0h want req=1 addr=0", bus.imem_req_o, bus.imem_addr_o); end
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = word(16'h0000);
        cycle();
        bus.imem_ack_i = 1'b0;
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 16'h0000) begin
            errors++; $display("FAIL halt_deliver got v=%0h pc=%0h want v=1 pc=0", bus.inst_valid_o, bus.inst_pc_o); end
        cycle();
        cycle();
        checks++; if (bus.busy_o !== 1'b0 || bus.imem_req_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL halt_idle got busy=%0h req=%0h v=%0h want 0 0 0", bus.busy_o, bus.imem_req_o, bus.inst_valid_o); end
        bus.halt_i = 1'b0;
        cycle();
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 16'h0004 || bus.busy_o !== 1'b1) begin
            errors++; $display("FAIL halt_resume got req=%0h addr=%0h busy=%0h want req=1 addr=4 busy=1", bus.imem_req_o, bus.imem_addr_o, bus.busy_o); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        cycle();
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = word(16'h0000);
        cycle();
        bus.imem_ack_i = 1'b0;
        cycle();
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 16'h0004) begin
            errors++; $display("FAIL arst_pre got req=%0h addr=%0h want req=1 addr=4", bus.imem_req_o, bus.imem_addr_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 16'h0000 || bus.busy_o !== 1'b0 || bus.inst_pc_o !== 16'h0000) begin
            errors++; $display("FAIL arst_async got req=%0h addr=%0h busy=%0h pc=%0h want 0 0 0 0", bus.imem_req_o, bus.imem_addr_o, bus.busy_o, bus.inst_pc_o); end
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = word(16'h0004);
        cycle();
        bus.imem_ack_i = 1'b0;
        rst_n = 1'b1;
        checks++; if (bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin
            errors++; $display("FAIL arst_ignored got v=%0h req=%0h want 0 0", bus.inst_valid_o, bus.imem_req_o); end
        cycle();
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 16'h0000) begin
            errors++; $display("FAIL arst_restart got req=%0h addr=%0h want req=1 addr=0", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_redirect_wait();
        test_latest_redirect();
        test_redirect_ack();
        test_stall();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the 16-bit single-cycle CPU. Owns the program counter and runs a request/acknowledge handshake with instruction memory. Presents each fetched instruction to decode with a valid/ready handshake. Applies branch redirects from execute, including redirects that arrive while a fetch is still outstanding, and discards any instruction fetched down the wrong path.

## Interface
Parameters:
- ADDR_W, 16, PC / memory address width
- DATA_W, 32, instruction width
- RESET_PC, 16'h0000, PC value after reset
- PC_STEP, 4, sequential PC increment

Ports:
- clk_i  in  1  clock; all state changes on its rising edge
- rst_n_i  in  1  reset; asynchronous, active-low
- halt_i  in  1  level; inhibits starting new fetches
- redirect_i  in  1  one-cycle pulse; branch/jump taken
- redirect_pc_i  in  ADDR_W  target address, valid when redirect_i=1
- imem_req_o  out  1  fetch request to instruction memory
- imem_addr_o  out  ADDR_W  fetch address, equal to the PC
- imem_ack_i  in  1  memory has data; sampled when imem_req_o=1
- imem_rdata_i  in  DATA_W  instruction word, valid with imem_ack_i
- inst_valid_o  out  1  instruction available to decode
- inst_o  out  DATA_W  captured instruction
- inst_pc_o  out  ADDR_W  address of inst_o
- inst_pc4_o  out  ADDR_W  inst_pc_o + PC_STEP (link value)
- inst_ready_i  in  1  decode accepts inst_o when inst_valid_o=1
- busy_o  out  1  1 when the FSM is not in IDLE

## Operation
- Registers: pc, pend_pc, kill flag, inst/inst_pc capture registers, 2-bit state.
- imem_addr_o is pc. imem_req_o is 1 only in REQ.
- IDLE: no request. If halt_i=0, go to REQ on the next edge.
- REQ: hold imem_req_o=1 with imem_addr_o stable until imem_ack_i=1. A request is never withdrawn, and halt_i is ignored in this state.
  - ack with kill=0 and redirect_i=0: capture rdata, inst_pc<=pc, pc<=pc+PC_STEP, go to OUT.
  - redirect_i=1 without ack: pend_pc<=redirect_pc_i, kill<=1, stay in REQ. pc and address do not change.
  - ack with kill=1 and no new redirect: discard rdata, pc<=pend_pc, kill<=0, stay in REQ.
  - ack with redirect_i=1 in the same cycle: discard rdata, pc<=redirect_pc_i, kill<=0, stay in REQ.
  - Several redirects during one outstanding fetch: the latest one wins.
- OUT: inst_valid_o=1; inst_o and inst_pc_o are held stable.
  - redirect_i=1 has priority over inst_ready_i. The instruction is dropped (not consumed), pc<=redirect_pc_i, go to REQ (or IDLE if halt_i=1).
  - inst_ready_i=1: handshake completes. Go to IDLE if halt_i=1, else REQ.
  - Otherwise stay in OUT.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFC+4 wraps to 16'h0000. redirect_pc_i is used unmodified, with no alignment check.
- inst_pc4_o = inst_pc_o + PC_STEP, combinational and also truncated to ADDR_W.

## Timing
- Reset values: state=IDLE, pc=pend_pc=RESET_PC, kill=0, imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, inst_pc4_o=PC_STEP, busy_o=0.
- Reset deassertion with halt_i=0: imem_req_o rises after the first clock edge.
- Ack in the first REQ cycle gives inst_valid_o one edge later. Peak throughput is one instruction per 2 cycles.
- Redirect latency: the new target appears on imem_addr_o the edge after the redirect, provided no fetch is outstanding.
- Reset asserted mid-fetch or mid-OUT: all state returns to the reset values immediately (asynchronously). Any memory response that arrives after reset is ignored because imem_req_o=0.

## Test plan
- Reset, halt_i=0, memory acks in the first REQ cycle, decode always ready: addresses 0,4,8,C requested; inst_pc_o sequence 0,4,8,C; inst_valid_o high every second cycle.
- Memory acks 3 cycles after req, redirect to 16'h0040 in the 2nd wait cycle: address 0 held until ack, its data never appears on inst_valid_o, next request is to 0x40.
- Redirect to 16'h0100 coinciding with ack: rdata discarded, next request is to 0x100.
- inst_ready_i held low for 5 cycles in OUT: inst_valid_o/inst_o/inst_pc_o stable, imem_req_o=0. Then a redirect to 0x20 drops the instruction and the next request is to 0x20.
- pc=16'hFFFC fetched: inst_pc4_o=0, next address 0x0000.
- halt_i=1 while in REQ: fetch completes and is delivered, then FSM goes to IDLE with busy_o=0. Deassert halt_i: the next request uses the advanced PC.
- rst_n_i pulsed low during REQ: imem_req_o drops without waiting for a clock edge, then fetching restarts at RESET_PC.
